dcache_responder: RTL
=====================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of address, write-data and read-data buses.
REQ-002 Parameter MEM_WORDS_LOG2, default 6: log2 of backing-store depth in DATA_WIDTH words (64 words).
REQ-003 Parameter FIFO_DEPTH, default 4: request queue capacity, power of two, minimum 2.
REQ-004 Parameter LATENCY, default 3: service cycles per request, minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_addr_in  input  DATA_WIDTH  byte address of request.
REQ-008 req_data_in  input  DATA_WIDTH  write data; ignored for reads.
REQ-009 req_rw_in  input  1  0 = read, 1 = write.
REQ-010 req_id_in  input  4  requester tag, returned unchanged with the response.
REQ-011 req_valid_in  input  1  request present this cycle.
REQ-012 resp_data_out  output  DATA_WIDTH  read data, or written data for write acks.
REQ-013 resp_id_out  output  4  tag of the completing request.
REQ-014 resp_ready_out  output  1  one-cycle pulse: resp_data_out/resp_id_out valid.
REQ-015 stall_out  output  1  queue full; requester shall hold its request.

Function
REQ-016 Accept SHALL occur at a rising edge where req_valid_in=1 and stall_out=0; addr, data, rw and id SHALL be pushed into the FIFO.
REQ-017 req_valid_in=1 while stall_out=1 SHALL be ignored: no push, no state change.
REQ-018 stall_out SHALL equal (count == FIFO_DEPTH), decoded from the registered occupancy count only (no combinational path from req_valid_in).
REQ-019 Push and pop at the same edge SHALL leave count unchanged; push is legal at full only if a pop occurs at the same edge. Because stall_out=1 at full, this case does not arise at the interface.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL range 0..FIFO_DEPTH.
REQ-021 Service FSM states: IDLE, BUSY, RESP.
REQ-022 IDLE with FIFO non-empty: pop the head into the service register, load cnt = LATENCY-1, go to BUSY. IDLE with FIFO empty: stay in IDLE.
REQ-023 BUSY with cnt != 0: decrement cnt. BUSY with cnt == 0: perform the access, register the response, go to RESP.
REQ-024 RESP: resp_ready_out=1 for exactly this cycle. Next state is BUSY (with pop and cnt reload) if the FIFO is non-empty, otherwise IDLE.
REQ-025 resp_ready_out SHALL be 0 in IDLE and BUSY. resp_data_out and resp_id_out SHALL hold their last values outside RESP.
REQ-026 Latency: a request accepted at edge N with the FIFO empty and the FSM in IDLE SHALL raise resp_ready_out after edge N+LATENCY+1, for one cycle.
REQ-027 Throughput: back-to-back queued requests SHALL complete one per LATENCY+1 cycles.
REQ-028 Word index SHALL be req_addr_in[MEM_WORDS_LOG2+1:2]. Bits [1:0] and higher bits SHALL be ignored, so addresses alias modulo 4*2^MEM_WORDS_LOG2.
REQ-029 A write SHALL update the memory at the BUSY->RESP edge. resp_data_out SHALL equal the written data.
REQ-030 A read SHALL return the memory word as of the BUSY->RESP edge.
REQ-031 Requests SHALL complete strictly in acceptance order, so a read following a write to the same index SHALL return the new data.

Reset
REQ-032 On reset=1, asynchronously: FSM=IDLE, count=0, pointers=0, cnt=0, resp_ready_out=0, resp_data_out=0, resp_id_out=0, stall_out=0, all memory words=0.
REQ-033 Reset mid-operation SHALL discard queued and in-service requests. No response SHALL be issued for them.
REQ-034 After reset deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 Write/read (LATENCY=3): write addr 0x10, data 0xDEADBEEF, id 5 accepted at edge 0 -> resp_ready_out=1 only after edge 4, resp_id_out=5, resp_data_out=0xDEADBEEF. Then read addr 0x10, id 6 -> resp_data_out=0xDEADBEEF, resp_id_out=6.
REQ-036 Full queue: 6 consecutive valid reads, ids 0..5, from idle -> stall_out=1 once count=4. The held request is accepted only after a pop. Responses return with ids 0..5 in order, spaced 4 cycles apart.
REQ-037 Aliasing: write 0x12345678 to addr 0x100, then read addr 0x000 and addr 0x003 -> both return 0x12345678.
REQ-038 Simultaneous push/pop: with count=2, a push at the same edge as the RESP->BUSY pop -> count stays 2 and stall_out stays 0.
REQ-039 Reset mid-operation: queue 3 requests, assert reset while BUSY -> all outputs 0 immediately; no resp_ready_out pulse after deassert; a read of a previously written address returns 0.
REQ-040 Post-reset reads: read any address immediately after reset -> resp_data_out=0 with the matching id.

Source files
------------

// File: rtl/dcache_responder.sv
// dcache_responder: queued, fixed-latency responder for a simple data-cache port.
//
// Requests are pushed into a FIFO_DEPTH-entry queue. A three-state service FSM pops one
// request at a time, waits LATENCY cycles, performs the read or write against a
// 2**MEM_WORDS_LOG2-word backing store, and presents the result for one cycle.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_addr_in         byte address (word index taken from bits [MEM_WORDS_LOG2+1:2])
//   req_data_in         write data
//   req_rw_in           0 = read, 1 = write
//   req_id_in           requester tag, echoed on the response
//   req_valid_in        request present; accepted when stall_out is low
//   resp_data_out       read data, or the written data for a write
//   resp_id_out         tag of the completing request
//   resp_ready_out      one-cycle response strobe
//   stall_out           queue full; requester must hold its request
module dcache_responder #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_WORDS_LOG2 = 6,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned LATENCY        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] req_addr_in,
    input  logic [DATA_WIDTH-1:0] req_data_in,
    input  logic                  req_rw_in,
    input  logic [3:0]            req_id_in,
    input  logic                  req_valid_in,
    output logic [DATA_WIDTH-1:0] resp_data_out,
    output logic [3:0]            resp_id_out,
    output logic                  resp_ready_out,
    output logic                  stall_out
);

    localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CountW   = PtrW + 1;
    localparam int unsigned CntW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned MemWords = 2 ** MEM_WORDS_LOG2;

    localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);
    localparam logic [CntW-1:0]   CntLoad   = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    // Only the word index matters; the byte offset and upper bits alias.
    logic [MEM_WORDS_LOG2-1:0] req_idx;
    logic                      unused_addr_bits;
    assign req_idx          = req_addr_in[MEM_WORDS_LOG2+1:2];
    assign unused_addr_bits = ^{req_addr_in[DATA_WIDTH-1:MEM_WORDS_LOG2+2], req_addr_in[1:0]};

    // Request queue storage (no reset needed: guarded by count_q).
    logic [MEM_WORDS_LOG2-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data_q [FIFO_DEPTH];
    logic                      fifo_rw_q   [FIFO_DEPTH];
    logic [3:0]                fifo_id_q   [FIFO_DEPTH];

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [MEM_WORDS_LOG2-1:0] svc_idx_q, svc_idx_d;
    logic [DATA_WIDTH-1:0]     svc_data_q, svc_data_d;
    logic                      svc_rw_q, svc_rw_d;
    logic [3:0]                svc_id_q, svc_id_d;
    logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
    logic [3:0]                resp_id_q, resp_id_d;

    logic [DATA_WIDTH-1:0] mem_q [MemWords];
    logic                  mem_we;

    logic push, pop, fifo_empty;

    // Stall comes from the registered count only, so there is no path from req_valid_in.
    assign stall_out      = (count_q == CountFull);
    assign fifo_empty     = (count_q == '0);
    assign push           = req_valid_in && !stall_out;
    assign resp_ready_out = (state_q == StResp);
    assign resp_data_out  = resp_data_q;
    assign resp_id_out    = resp_id_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        svc_idx_d   = svc_idx_q;
        svc_data_d  = svc_data_q;
        svc_rw_d    = svc_rw_q;
        svc_id_d    = svc_id_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        pop         = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Read sees the store before this edge's write (writes only come from
                    // the request in service, so there is never a conflict).
                    mem_we      = svc_rw_q;
                    resp_data_d = svc_rw_q ? svc_data_q : mem_q[svc_idx_q];
                    resp_id_d   = svc_id_q;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            svc_idx_d  = fifo_idx_q[rd_ptr_q];
            svc_data_d = fifo_data_q[rd_ptr_q];
            svc_rw_d   = fifo_rw_q[rd_ptr_q];
            svc_id_d   = fifo_id_q[rd_ptr_q];
            cnt_d      = CntLoad;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= req_idx;
            fifo_data_q[wr_ptr_q] <= req_data_in;
            fifo_rw_q[wr_ptr_q]   <= req_rw_in;
            fifo_id_q[wr_ptr_q]   <= req_id_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            svc_idx_q   <= '0;
            svc_data_q  <= '0;
            svc_rw_q    <= 1'b0;
            svc_id_q    <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            svc_idx_q   <= svc_idx_d;
            svc_data_q  <= svc_data_d;
            svc_rw_q    <= svc_rw_d;
            svc_id_q    <= svc_id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MemWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[svc_idx_q] <= svc_data_q;
        end
    end

endmodule
